// File: rtl/ins_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ins_fetch_unit
// Description : Dual-lane instruction fetch front end. Reads instruction
//               pairs from a synchronous instruction memory into a 2-entry
//               fetch buffer, tags each instruction with a branch id and
//               pushes up to two instructions per cycle into the instruction
//               queue. Handles halt and branch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module ins_fetch_unit #(
    parameter int TOTAL_IN  = 16,
    parameter int PC_WIDTH  = 8,
    parameter int BRANCH_ID = 3,
    parameter int RESET_PC  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_rd,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic [TOTAL_IN-1:0]  imem_data0,
    input  logic [TOTAL_IN-1:0]  imem_data1,
    input  logic [1:0]           q_free,
    output logic                 ins0_push,
    output logic                 ins1_push,
    output logic [TOTAL_IN-1:0]  ins0,
    output logic [TOTAL_IN-1:0]  ins1,
    output logic [PC_WIDTH-1:0]  ins0_pc,
    output logic [PC_WIDTH-1:0]  ins1_pc,
    output logic [BRANCH_ID-1:0] ins0_bid,
    output logic [BRANCH_ID-1:0] ins1_bid,
    input  logic                 redirect_valid,
    input  logic [PC_WIDTH-1:0]  redirect_pc,
    output logic                 halted
);

    localparam logic [3:0]          c_op_branch = 4'hB;
    localparam logic [3:0]          c_op_halt   = 4'hF;
    localparam logic [PC_WIDTH-1:0] c_reset_pc  = PC_WIDTH'(RESET_PC);

    localparam logic [0:0] c_st_fetch = 1'b0;
    localparam logic [0:0] c_st_halt  = 1'b1;

    logic [0:0]           r_state;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [PC_WIDTH-1:0]  r_fetch_pc;
    logic                 r_inflight;
    logic [BRANCH_ID-1:0] r_bcnt;
    logic                 r_v0;
    logic                 r_v1;
    logic [TOTAL_IN-1:0]  r_ins0;
    logic [TOTAL_IN-1:0]  r_ins1;
    logic [PC_WIDTH-1:0]  r_pc0;
    logic [PC_WIDTH-1:0]  r_pc1;
    logic [BRANCH_ID-1:0] r_bid0;
    logic [BRANCH_ID-1:0] r_bid1;

    logic                 w_push0;
    logic                 w_push1;
    logic                 w_empty_next;
    logic                 w_rd;
    logic [3:0]           w_op0;
    logic [3:0]           w_op1;
    logic                 w_br0;
    logic                 w_br1;
    logic                 w_halt0;
    logic                 w_halt1;
    logic [BRANCH_ID-1:0] w_bid1_load;
    logic [BRANCH_ID-1:0] w_bcnt_load;

    // Push handshake, read issue and branch-tag arithmetic for returning data
    always_comb begin
        w_push0      = r_v0 && (q_free >= 2'd1) && !redirect_valid;
        // lane 1 only goes out together with lane 0 so queue order is kept
        w_push1      = r_v1 && (q_free >= 2'd2) && w_push0;
        w_empty_next = !r_v0 || (w_push0 && (!r_v1 || w_push1));
        // gated by rst so every output is quiet while reset is held
        w_rd         = !rst && (r_state == c_st_fetch) && !r_inflight &&
                       !redirect_valid && w_empty_next;

        w_op0        = imem_data0[TOTAL_IN-1 -: 4];
        w_op1        = imem_data1[TOTAL_IN-1 -: 4];
        w_halt0      = (w_op0 == c_op_halt);
        w_halt1      = (w_op1 == c_op_halt);
        w_br0        = (w_op0 == c_op_branch);
        // a lane 1 dropped behind a halt must not consume a branch tag
        w_br1        = (w_op1 == c_op_branch) && !w_halt0;
        w_bid1_load  = r_bcnt + BRANCH_ID'(w_br0);
        w_bcnt_load  = w_bid1_load + BRANCH_ID'(w_br1);
    end

    assign imem_rd   = w_rd;
    assign imem_addr = w_rd ? r_pc : '0;
    assign ins0_push = w_push0;
    assign ins1_push = w_push1;
    assign ins0      = r_ins0;
    assign ins1      = r_ins1;
    assign ins0_pc   = r_pc0;
    assign ins1_pc   = r_pc1;
    assign ins0_bid  = r_bid0;
    assign ins1_bid  = r_bid1;
    assign halted    = (r_state == c_st_halt);

    // Fetch state machine: redirect, memory return load, buffer drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_fetch;
            r_pc       <= c_reset_pc;
            r_fetch_pc <= '0;
            r_inflight <= 1'b0;
            r_bcnt     <= '0;
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
            r_ins0     <= '0;
            r_ins1     <= '0;
            r_pc0      <= '0;
            r_pc1      <= '0;
            r_bid0     <= '0;
            r_bid1     <= '0;
        end else if (redirect_valid) begin
            // data returning this cycle belongs to the wrong path and is dropped
            r_state    <= c_st_fetch;
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
        end else begin
            r_inflight <= w_rd;
            if (w_rd) begin
                r_fetch_pc <= r_pc;
                r_pc       <= r_pc + PC_WIDTH'(2);
            end
            if (r_inflight) begin
                // a read is only issued when the buffer drains, so it is empty here
                r_ins0 <= imem_data0;
                r_pc0  <= r_fetch_pc;
                r_bid0 <= r_bcnt;
                r_v0   <= 1'b1;
                r_ins1 <= imem_data1;
                r_pc1  <= r_fetch_pc + PC_WIDTH'(1);
                r_bid1 <= w_bid1_load;
                r_v1   <= !w_halt0;
                r_bcnt <= w_bcnt_load;
                if (w_halt0 || w_halt1) begin
                    r_state <= c_st_halt;
                end
            end else if (w_push0) begin
                if (r_v1 && !w_push1) begin
                    // lane 1 moves forward so the oldest instruction is always lane 0
                    r_ins0 <= r_ins1;
                    r_pc0  <= r_pc1;
                    r_bid0 <= r_bid1;
                    r_v1   <= 1'b0;
                end else begin
                    r_v0 <= 1'b0;
                    r_v1 <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
